// File: rtl/sha_pad_pkg.sv
// Shared types and constants for the SHA-384/512 message padder.
// 64-bit words, 16-word blocks, 128-bit length trailer.
package sha_pad_pkg;

    localparam int WORD_W      = 64;
    localparam int BLOCK_WORDS = 16;
    localparam int IDX_W       = $clog2(BLOCK_WORDS);
    localparam int LEN_W       = 128;

    localparam logic [IDX_W-1:0] LEN_HI_IDX = 4'd14;

    typedef enum logic [2:0] {
        ST_MSG,
        ST_ZERO,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DONE
    } state_t;

endpackage

// File: rtl/sha_pad_mask.sv
// Final-word shaping: keep the top k bits, insert the '1' pad bit
// directly below them and clear everything further down.
module sha_pad_mask
    import sha_pad_pkg::*;
(
    input  logic [WORD_W-1:0] word_in,
    input  logic [5:0]        k,
    output logic [WORD_W-1:0] word_out
);

    localparam logic [WORD_W-1:0] ONES = '1;
    localparam logic [WORD_W-1:0] PAD  = {1'b1, {(WORD_W-1){1'b0}}};

    assign word_out = (word_in & ~(ONES >> k)) | (PAD >> k);

endmodule

// File: rtl/sha_padding.sv
// Streaming SHA-384/512 padder: passes message words, then emits the
// pad bit, zero fill and the 128-bit big-endian bit length.
module sha_padding
    import sha_pad_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] word_in,
    input  logic [6:0]        word_in_bits,
    input  logic              next_word,
    output logic [WORD_W-1:0] word_out,
    output logic              msg_complete
);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [LEN_W-1:0] len;

    logic              full;
    logic [6:0]        eff_bits;
    logic [IDX_W-1:0]  idx_inc;
    logic [WORD_W-1:0] masked;
    logic [WORD_W-1:0] msg_word;
    logic              start;

    // Bit counts above 64 count as a full word.
    assign full     = word_in_bits[6];
    assign eff_bits = full ? 7'd64 : word_in_bits;
    assign idx_inc  = idx + 4'd1;

    sha_pad_mask u_mask (
        .word_in  (word_in),
        .k        (word_in_bits[5:0]),
        .word_out (masked)
    );

    assign msg_word = full ? word_in : masked;

    // A zero-length word in DONE is not a new message.
    assign start = (state == ST_MSG) ||
                   ((state == ST_DONE) && (word_in_bits != 7'd0));

    always_comb begin
        word_out = '0;
        unique case (state)
            ST_MSG:    word_out = msg_word;
            ST_ZERO:   word_out = '0;
            ST_LEN_HI: word_out = len[LEN_W-1:WORD_W];
            ST_LEN_LO: word_out = len[WORD_W-1:0];
            ST_DONE:   word_out = start ? msg_word : '0;
            default:   word_out = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_MSG;
            idx          <= '0;
            len          <= '0;
            msg_complete <= 1'b0;
        end else if (next_word) begin
            unique case (state)
                ST_MSG, ST_DONE: begin
                    if (start) begin
                        if (state == ST_DONE)
                            len <= LEN_W'(eff_bits);
                        else
                            len <= len + LEN_W'(eff_bits);
                        idx          <= idx_inc;
                        msg_complete <= 1'b0;
                        if (full)
                            state <= ST_MSG;
                        else if (idx_inc == LEN_HI_IDX)
                            state <= ST_LEN_HI;
                        else
                            state <= ST_ZERO;
                    end
                end
                ST_ZERO: begin
                    idx <= idx_inc;
                    if (idx_inc == LEN_HI_IDX)
                        state <= ST_LEN_HI;
                end
                ST_LEN_HI: begin
                    idx   <= idx_inc;
                    state <= ST_LEN_LO;
                end
                ST_LEN_LO: begin
                    idx          <= '0;
                    msg_complete <= 1'b1;
                    state        <= ST_DONE;
                end
                default: state <= ST_MSG;
            endcase
        end
    end

endmodule

// File: tb/tb_sha_padding.sv
// Directed bench for sha_padding: vector tables per message plus
// hand-written reset sequences.
module tb_sha_padding;

    logic        clk;
    logic        reset;
    logic [63:0] word_in;
    logic [6:0]  word_in_bits;
    logic        next_word;
    logic [63:0] word_out;
    logic        msg_complete;

    int total = 0;
    int bad   = 0;

    sha_padding dut (
        .clk          (clk),
        .reset        (reset),
        .word_in      (word_in),
        .word_in_bits (word_in_bits),
        .next_word    (next_word),
        .word_out     (word_out),
        .msg_complete (msg_complete)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  bits;
        logic [63:0] data;
        logic [63:0] exp;
        logic        mc;
        int          stall;
    } vec_t;

    vec_t q[$];

    localparam logic [63:0] PAD0 = 64'h8000_0000_0000_0000;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic void push(logic [6:0] bits, logic [63:0] data,
                                 logic [63:0] exp, logic mc);
        vec_t v;
        v.bits  = bits;
        v.data  = data;
        v.exp   = exp;
        v.mc    = mc;
        v.stall = 0;
        q.push_back(v);
    endfunction

    // Zero words from idx up to 13, then the two length words.
    function automatic void push_tail(int idx, logic [127:0] len);
        int i;
        i = idx;
        while (i != 14) begin
            push(7'd0, {$urandom, $urandom}, 64'h0, 1'b0);
            i = (i + 1) % 16;
        end
        push(7'd0, {$urandom, $urandom}, len[127:64], 1'b0);
        push(7'd0, {$urandom, $urandom}, len[63:0], 1'b1);
    endfunction

    task automatic apply(string name, int n, vec_t v);
        string tag;
        tag = $sformatf("%s[%0d]", name, n);
        @(negedge clk);
        word_in      = v.data;
        word_in_bits = v.bits;
        next_word    = 1'b0;
        for (int s = 0; s < v.stall; s++) begin
            #1 chk({tag, " stall"}, word_out, v.exp);
            @(negedge clk);
        end
        next_word = 1'b1;
        #1 chk({tag, " word"}, word_out, v.exp);
        @(posedge clk);
        #1 chk({tag, " mc"}, {63'h0, msg_complete}, {63'h0, v.mc});
        next_word = 1'b0;
    endtask

    task automatic run_q(string name);
        foreach (q[i]) apply(name, i, q[i]);
        q.delete();
    endtask

    initial begin
        logic [63:0] d;

        reset        = 1'b0;
        next_word    = 1'b0;
        word_in      = 64'h0;
        word_in_bits = 7'd0;
        #1 chk("reset word", word_out, PAD0);
        chk("reset mc", {63'h0, msg_complete}, 64'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Empty message
        push(7'd0, 64'h1234_5678_9abc_def0, PAD0, 1'b0);
        push_tail(1, 128'd0);
        run_q("empty");

        // "abc", stalled on the last length word
        push(7'd24, 64'h6162_63aa_bbcc_ddee, 64'h6162_6380_0000_0000, 1'b0);
        push_tail(1, 128'd24);
        q[q.size()-1].stall = 3;
        q[5].stall = 3;
        run_q("abc");

        // 888-bit message; one word uses an over-range bit count
        for (int i = 0; i < 13; i++) begin
            d = {$urandom, $urandom};
            push((i == 4) ? 7'd100 : 7'd64, d, d, 1'b0);
        end
        push(7'd56, 64'h6e6f_7071_7273_7475, 64'h6e6f_7071_7273_7480, 1'b0);
        push_tail(14, 128'd888);
        run_q("m888");

        // Final word at idx 14 spills padding into a second block
        for (int i = 0; i < 14; i++) begin
            d = {$urandom, $urandom};
            push(7'd64, d, d, 1'b0);
        end
        push(7'd8, 64'hab11_2233_4455_6677, 64'hab80_0000_0000_0000, 1'b0);
        push_tail(15, 128'd904);
        run_q("ovf");

        // Back-to-back: one full word, then bits=0 terminator
        push(7'd64, 64'hfeed_face_cafe_beef, 64'hfeed_face_cafe_beef, 1'b0);
        push(7'd0, 64'h0123_4567_89ab_cdef, PAD0, 1'b0);
        push_tail(2, 128'd64);
        run_q("b2b");

        // Idle DONE with bits=0 and next_word must not restart
        @(negedge clk);
        word_in_bits = 7'd0;
        word_in      = 64'hffff_ffff_ffff_ffff;
        next_word    = 1'b1;
        #1 chk("done idle word", word_out, 64'h0);
        @(posedge clk);
        #1 chk("done idle mc", {63'h0, msg_complete}, 64'h1);
        next_word = 1'b0;

        // Reset in the middle of zero fill at idx 5
        push(7'd24, 64'h6162_6300_0000_0000, 64'h6162_6380_0000_0000, 1'b0);
        for (int i = 0; i < 4; i++) push(7'd0, 64'h0, 64'h0, 1'b0);
        run_q("pre_rst");
        @(negedge clk);
        word_in      = 64'h6162_6300_0000_0000;
        word_in_bits = 7'd24;
        #1 chk("zero idx5 word", word_out, 64'h0);
        reset = 1'b0;
        #1 chk("rst mid word", word_out, 64'h6162_6380_0000_0000);
        chk("rst mid mc", {63'h0, msg_complete}, 64'h0);
        @(negedge clk);
        reset = 1'b1;

        push(7'd24, 64'h6162_6300_0000_0000, 64'h6162_6380_0000_0000, 1'b0);
        push_tail(1, 128'd24);
        run_q("abc2");

        // Reset while complete clears msg_complete at once
        @(negedge clk);
        word_in_bits = 7'd0;
        reset        = 1'b0;
        #1 chk("rst done mc", {63'h0, msg_complete}, 64'h0);
        chk("rst done word", word_out, PAD0);
        @(negedge clk);
        reset = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sha_padding.md
Name: sha_padding

Overview:
- Streaming message padder for SHA-384/512-style hashing: 64-bit words, 1024-bit (16-word) blocks, 128-bit big-endian bit-length trailer.
- Passes message words through, then inserts the single '1' bit, zero fill and the length words.
- Output is a padded word stream for the downstream compression core.
- Sits between the message source and the SHA round engine.

Parameters:
- none. Widths are fixed: word 64, block 16 words, length field 128.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- word_in  in  64  message word, MSB-first; valid data is MSB-justified
- word_in_bits  in  7  number of valid bits in word_in (0..64); <64 marks the final message word
- next_word  in  1  advance enable; when low all state holds
- word_out  out  64  padded output word (combinational from state and word_in)
- msg_complete  out  1  registered; high once the length-low word has been consumed

Behaviour:
- States: MSG (pass data), ZERO (zero fill), LEN_HI, LEN_LO, DONE.
- Registers:
  - idx: 4-bit word index within the block, wraps mod 16.
  - len: 128-bit bit counter.
  - msg_complete.
- Reset (async, reset=0): state=MSG, idx=0, len=0, msg_complete=0. word_out follows the MSG-state rule.
- word_out is combinational and must be valid in the same cycle as word_in (zero-cycle latency). Downstream samples it on the clock edge where next_word=1.
- MSG, word_in_bits=64:
  - word_out=word_in.
  - On next_word: len+=64, idx++.
- MSG, word_in_bits=k<64 (final word):
  - word_out keeps bits [63:64-k] of word_in, sets bit 63-k to 1, and clears bits below it.
  - On next_word: len+=k, idx++.
  - Next state: LEN_HI if new idx==14, else ZERO.
- ZERO:
  - word_out=0. word_in is ignored.
  - On next_word: idx++. Go to LEN_HI when new idx==14.
  - Covers the overflow case: a final word at idx 14 or 15 fills the rest of the block with zeros, then continues zeros through idx 13 of the next block.
- LEN_HI: word_out=len[127:64]; on next_word: idx++, go to LEN_LO.
- LEN_LO: word_out=len[63:0]; on next_word: idx becomes 0, msg_complete<=1, go to DONE.
- DONE:
  - word_out=0; msg_complete stays 1.
  - next_word with word_in_bits>0 starts a new message in the same cycle:
    - word_out is processed exactly as in MSG.
    - len loads word_in_bits instead of accumulating.
    - msg_complete<=0.
    - State follows the MSG rules.
  - next_word with word_in_bits=0 is ignored.
- word_in_bits values 65..127 are treated as 64.
- A message of whole 64-bit words is terminated by presenting word_in_bits=0. This emits 0x8000_0000_0000_0000.
- len wraps modulo 2^128.
- With next_word=0: no register changes; word_out reflects current state and current word_in.
- Reset asserted mid-message aborts immediately; no partial padding is emitted.

Decomposition:
- Package sha_pad_pkg:
  - state enum.
  - Constants WORD_W=64, BLOCK_WORDS=16, LEN_W=128, LEN_HI_IDX=14.
- One natural sub-module, sha_pad_mask. It is combinational: (word_in, k) -> masked word with the pad bit inserted.
- Top level: FSM, idx and len counters, output mux.

Test Plan:
- 888-bit message ("abcdefghbcdefghi...nopqrst"): 13 words at 64 bits, then 1 word at 56 bits, then word_in_bits=0 for 2 cycles.
  - Words 0..12 echo the input.
  - Word 13 = top 7 bytes plus 0x80.
  - Word 14 = 0; word 15 = 0x378.
  - msg_complete=1 after word 15.
- "abc" (one word, bits=24, data 0x616263xx...):
  - Word 0 = 0x6162638000000000.
  - Words 1..14 = 0; word 15 = 0x18.
  - msg_complete=1.
- Empty message (first word bits=0): word 0 = 0x8000000000000000, words 1..15 = 0, msg_complete=1.
- Overflow case: 14 full words, then bits=8 at idx 14.
  - Word 14 = byte plus 0x80.
  - Word 15 = 0.
  - Second block: words 0..13 = 0, word 14 = 0, word 15 = 0x388 (904).
- Stall and back-to-back:
  - next_word low for 3 cycles mid-padding: idx, len and word_out are held.
  - After DONE, a new full word restarts: msg_complete drops, len=64.
- Reset mid-message (drive reset low at idx 5): outputs return to reset values immediately; a subsequent "abc" pads correctly.
